// File: rtl/rtc_bcd_clock.sv
// rtc_bcd_clock: BCD time-of-day clock advanced by rising edges of an upstream tick, with a register slave port.
// Optional alarm compare and alarm interrupt are built only when RTC_ALARM_EN is defined.
`default_nettype none

module rtc_bcd_clock #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

    // Out-of-range digits or fields wrap to 00 and carry instead of counting on.
    function automatic logic bcd_carry(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (bcd_carry(v, max))
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       tick_q;
    logic [7:0] presc;
    logic [7:0] sec, min, hour;
    logic       run, sec_ie, alarm_ie;
    logic       sec_evt, alarm_hit;

    logic       wr, wr_status, wr_ctrl, wr_tlo, wr_thi;
    logic       tick_cnt, sec_step, step;
    logic [7:0] sec_n, min_n, hour_n;

    assign wr        = chipselect && !write_n;
    assign wr_status = wr && (address == 3'd0);
    assign wr_ctrl   = wr && (address == 3'd1);
    assign wr_tlo    = wr && (address == 3'd2);
    assign wr_thi    = wr && (address == 3'd3);

    assign tick_cnt = run && tick_in && !tick_q;
    assign sec_step = tick_cnt && (presc == PRESC_LAST);
    // A software time write wins: the whole step is discarded, not just the written field.
    assign step     = sec_step && !(wr_tlo || wr_thi);

    assign sec_n  = bcd_inc(sec, 8'h59);
    assign min_n  = bcd_carry(sec, 8'h59) ? bcd_inc(min, 8'h59) : min;
    assign hour_n = (bcd_carry(sec, 8'h59) && bcd_carry(min, 8'h59)) ? bcd_inc(hour, 8'h23) : hour;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q  <= 1'b0;
            presc   <= 8'h00;
            sec     <= 8'h00;
            min     <= 8'h00;
            hour    <= 8'h00;
            run     <= 1'b0;
            sec_ie  <= 1'b0;
            sec_evt <= 1'b0;
        end else begin
            tick_q <= tick_in;

            if (wr_ctrl && !writedata[0])
                presc <= 8'h00;
            else if (sec_step)
                presc <= 8'h00;
            else if (tick_cnt)
                presc <= presc + 8'd1;

            if (wr_tlo)
                {min, sec} <= writedata;
            else if (step)
                {min, sec} <= {min_n, sec_n};

            if (wr_thi)
                hour <= writedata[7:0];
            else if (step)
                hour <= hour_n;

            if (wr_ctrl) begin
                run    <= writedata[0];
                sec_ie <= writedata[1];
            end

            if (step)
                sec_evt <= 1'b1;
            else if (wr_status)
                sec_evt <= 1'b0;
        end
    end

`ifdef RTC_ALARM_EN
    logic [7:0] al_sec, al_min, al_hour;
    logic       wr_alo, wr_ahi;

    assign wr_alo = wr && (address == 3'd4);
    assign wr_ahi = wr && (address == 3'd5);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_sec    <= 8'h00;
            al_min    <= 8'h00;
            al_hour   <= 8'h00;
            alarm_ie  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            if (wr_alo)
                {al_min, al_sec} <= writedata;
            if (wr_ahi)
                al_hour <= writedata[7:0];
            if (wr_ctrl)
                alarm_ie <= writedata[2];
            // Compare the time this step is about to load, so the hit lands with the new time.
            if (step && ({hour_n, min_n, sec_n} == {al_hour, al_min, al_sec}))
                alarm_hit <= 1'b1;
            else if (wr_status)
                alarm_hit <= 1'b0;
        end
    end
`else
    assign alarm_ie  = 1'b0;
    assign alarm_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0000;
        end else begin
            case (address)
                3'd0:    readdata <= {13'h0000, run, alarm_hit, sec_evt};
                3'd1:    readdata <= {13'h0000, alarm_ie, sec_ie, run};
                3'd2:    readdata <= {min, sec};
                3'd3:    readdata <= {8'h00, hour};
`ifdef RTC_ALARM_EN
                3'd4:    readdata <= {al_min, al_sec};
                3'd5:    readdata <= {8'h00, al_hour};
`endif
                default: readdata <= 16'h0000;
            endcase
        end
    end

    assign irq = (sec_evt && sec_ie) || (alarm_hit && alarm_ie);

endmodule

`default_nettype wire

// File: tb/tb_rtc_bcd_clock.sv
// tb_rtc_bcd_clock: scoreboard bench driving two clocks (TICKS_PER_SEC 1 and 4) from one shared register bus.
`default_nettype none

module tb_rtc_bcd_clock;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] rd1, rd4;
    logic        irq1, irq4;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    rtc_bcd_clock #(.TICKS_PER_SEC(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .chipselect(chipselect),
        .write_n(write_n), .address(address), .writedata(writedata),
        .readdata(rd1), .irq(irq1)
    );

    rtc_bcd_clock #(.TICKS_PER_SEC(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .chipselect(chipselect),
        .write_n(write_n), .address(address), .writedata(writedata),
        .readdata(rd4), .irq(irq4)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step_clk();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected value is queued when the read is issued and popped when readdata is valid.
    task automatic rd(input bit slow, input logic [2:0] a, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        address = a;
        step_clk();
        check(tag_q.pop_front(), slow ? rd4 : rd1, exp_q.pop_front());
    endtask

    task automatic tick();
        tick_in = 1'b1;
        step_clk();
        step_clk();
        tick_in = 1'b0;
        step_clk();
        step_clk();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step_clk();
        check("reset_readdata", rd1, 16'h0000);
        check("reset_irq", 16'(irq1), 16'h0000);
        reset_n = 1'b1;
        step_clk();
        rd(0, 3'd0, 16'h0000, "reset_status");
        rd(0, 3'd2, 16'h0000, "reset_time_lo");

        // three ticks from midnight
        wr(3'd1, 16'h0001);
        wr(3'd2, 16'h0000);
        repeat (3) tick();
        rd(0, 3'd2, 16'h0003, "three_ticks");
        rd(0, 3'd0, 16'h0005, "status_evt_run");
        check("irq_sec_masked", 16'(irq1), 16'h0000);
        wr(3'd1, 16'h0003);
        check("irq_sec_enabled", 16'(irq1), 16'h0001);
        wr(3'd0, 16'h0000);
        check("irq_after_clear", 16'(irq1), 16'h0000);
        wr(3'd1, 16'h0001);

        // full-day rollover
        wr(3'd3, 16'h0023);
        wr(3'd2, 16'h5959);
        tick();
        rd(0, 3'd3, 16'h0000, "rollover_hi");
        rd(0, 3'd2, 16'h0000, "rollover_lo");

        // held level counts once
        tick_in = 1'b1;
        repeat (100) step_clk();
        tick_in = 1'b0;
        step_clk();
        rd(0, 3'd2, 16'h0001, "held_tick");

        // digit carries and out-of-range wrap points
        wr(3'd2, 16'h0959);
        tick();
        rd(0, 3'd2, 16'h1000, "min_digit_carry");
        wr(3'd2, 16'h5909);
        tick();
        rd(0, 3'd2, 16'h5910, "sec_digit_carry");
        wr(3'd2, 16'h003A);
        tick();
        rd(0, 3'd2, 16'h0100, "bad_sec_digit");
        wr(3'd3, 16'h0019);
        wr(3'd2, 16'hFFFF);
        rd(0, 3'd2, 16'hFFFF, "stored_unmodified");
        tick();
        rd(0, 3'd2, 16'h0000, "bad_fields_lo");
        rd(0, 3'd3, 16'h0020, "hour_digit_carry");

        // time write collides with a tick edge
        wr(3'd0, 16'h0000);
        tick_in = 1'b1;
        wr(3'd2, 16'h1000);
        tick_in = 1'b0;
        step_clk();
        rd(0, 3'd2, 16'h1000, "write_beats_step");
        rd(0, 3'd0, 16'h0004, "dropped_step_no_evt");

        // unmapped words
        wr(3'd6, 16'hABCD);
        rd(0, 3'd6, 16'h0000, "addr6_zero");
        rd(0, 3'd7, 16'h0000, "addr7_zero");

`ifdef RTC_ALARM_EN
        wr(3'd1, 16'h0000);
        wr(3'd4, 16'h0005);
        wr(3'd5, 16'h0000);
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0000);
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0005);
        rd(0, 3'd4, 16'h0005, "alarm_lo_rb");
        repeat (4) tick();
        check("alarm_irq_early", 16'(irq1), 16'h0000);
        tick_in = 1'b1;
        check("alarm_irq_pre", 16'(irq1), 16'h0000);
        step_clk();
        check("alarm_irq_rise", 16'(irq1), 16'h0001);
        tick_in = 1'b0;
        step_clk();
        rd(0, 3'd0, 16'h0007, "alarm_status");
        wr(3'd0, 16'h0000);
        check("alarm_irq_cleared", 16'(irq1), 16'h0000);
`else
        wr(3'd4, 16'h1234);
        rd(0, 3'd4, 16'h0000, "no_alarm_addr4");
        wr(3'd1, 16'h0007);
        rd(0, 3'd1, 16'h0003, "no_alarm_ctrl2");
`endif

        // prescaler of four
        wr(3'd1, 16'h0000);
        wr(3'd1, 16'h0001);
        wr(3'd2, 16'h0000);
        repeat (7) tick();
        rd(1, 3'd2, 16'h0001, "tps4_seven");
        rd(0, 3'd2, 16'h0007, "tps1_seven");
        tick();
        rd(1, 3'd2, 16'h0002, "tps4_eight");
        rd(0, 3'd2, 16'h0008, "tps1_eight");

        // asynchronous reset mid-run
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_rd", rd1, 16'h0000);
        step_clk();
        reset_n = 1'b1;
        step_clk();
        rd(0, 3'd2, 16'h0000, "post_reset_time");
        rd(0, 3'd1, 16'h0000, "post_reset_ctrl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rtc_bcd_clock.md
RTC_BCD_CLOCK -- requirements
Module: rtc_bcd_clock

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1, meaning the number of tick_in rising edges per one-second increment (range 1..255).
REQ-002 SHALL have port clk, input, 1, the system clock.
REQ-003 SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port tick_in, input, 1, the level from the upstream 1 s interval timer irq; only rising edges count.
REQ-005 SHALL have port chipselect, input, 1, the slave select.
REQ-006 SHALL have port write_n, input, 1, an active-low write strobe.
REQ-007 SHALL have port address, input, 3, the register word select.
REQ-008 SHALL have port writedata, input, 16, the write data.
REQ-009 SHALL have port readdata, output, 16, registered read data.
REQ-010 SHALL have port irq, output, 1, the level interrupt.

Function
REQ-011 SHALL use this register map; a write means chipselect && !write_n:
  - 0 STATUS: [0] sec_evt, [1] alarm_hit, [2] running; any write clears [1:0].
  - 1 CONTROL: [0] run, [1] sec_ie, [2] alarm_ie; R/W.
  - 2 TIME_LO: {min BCD, sec BCD}; R/W.
  - 3 TIME_HI: {8'h00, hour BCD}; R/W.
  - 4 ALARM_LO: {min, sec} BCD; R/W.
  - 5 ALARM_HI: {8'h00, hour} BCD; R/W.
  - 6-7: read 0, writes ignored.
REQ-012 SHALL register readdata with 1-cycle latency; it is updated every clock from address regardless of chipselect.
REQ-013 SHALL detect a tick as tick_in high while a registered copy of tick_in is low, so a held irq level counts once.
REQ-014 SHALL count ticks in an 8-bit prescaler only while run=1; on reaching TICKS_PER_SEC-1 plus a tick, it clears the prescaler and issues a 1-cycle sec_step.
REQ-015 SHALL apply sec_step as a BCD increment:
  - sec 59 -> 00 with carry to min;
  - min 59 -> 00 with carry to hour;
  - hour 23 -> 00.
  - 23:59:59 -> 00:00:00 in one step.
REQ-016 SHALL treat any digit >9, or any field above its max (sec/min >59, hour >23), as a wrap point on increment: the field becomes 00 and carries.
REQ-017 SHALL store written time/alarm values unmodified, with no validation.
REQ-018 SHALL give priority to a TIME_LO/TIME_HI write over a same-cycle sec_step: the written field takes the write, the sec_step is dropped entirely, and the prescaler clears.
REQ-019 SHALL clear the prescaler on a write to CONTROL with run=0; time is held.
REQ-020 SHALL set sec_evt on each sec_step, even if it is currently set.
REQ-021 SHALL give priority to a set over a same-cycle STATUS write-clear.
REQ-022 SHALL drive irq = (sec_evt && sec_ie) || (alarm_hit && alarm_ie) as a combinational result of registered bits.
REQ-023 SHALL reflect running = run.

Reset
REQ-024 SHALL clear on reset_n low, asynchronously: time 00:00:00, alarm 00:00:00, prescaler 0, CONTROL 0, STATUS bits 0, tick_in copy 0, readdata 0, irq 0.
REQ-025 SHALL ignore ticks during reset.
REQ-026 SHALL count the first rising tick_in edge after reset release if tick_in was low for at least one clock.

Configuration
REQ-027 SHALL, with RTC_ALARM_EN defined, set alarm_hit in the cycle after a sec_step whose new time equals ALARM_HI:ALARM_LO.
REQ-028 SHALL compare against the alarm only on a sec_step, never on writes.
REQ-029 SHALL, without RTC_ALARM_EN, remove the alarm registers and compare logic, read addresses 4-5 as 0, hold STATUS[1] and CONTROL[2] at 0, and reduce irq to sec_evt && sec_ie.

Verification
REQ-030 SHALL cover: set CONTROL=1 and TIME_LO=0x0000, then 3 tick_in pulses -> TIME_LO reads 0x0003 and sec_evt=1.
REQ-031 SHALL cover: TIME_HI=0x23 and TIME_LO=0x5959, then 1 tick -> TIME_HI reads 0x0000 and TIME_LO reads 0x0000.
REQ-032 SHALL cover: tick_in held high for 100 clocks -> exactly one increment.
REQ-033 SHALL cover: a TIME_LO=0x1000 write in the same cycle as a tick edge -> TIME_LO reads 0x1000, not 0x1001.
REQ-034 SHALL cover, with RTC_ALARM_EN: ALARM=00:00:05, CONTROL=0x5, 5 ticks -> irq rises one cycle after the 5th sec_step; a STATUS write clears it.
REQ-035 SHALL cover: TICKS_PER_SEC=4 and 7 ticks -> seconds=01 and prescaler residue 3; an 8th tick -> seconds=02.
